// File: rtl/ddr_hp_mport_pkg.sv
// Shared types and helpers for the DDR2 HP multi-port arbiter.
// Optional port-0 priority is enabled with DDR_HP_MPORT_PRIORITY_EN.
package ddr_hp_mport_pkg;

  typedef enum logic [1:0] {IDLE, RD_CMD, WR_BURST} state_e;

  // Tag fields are sized for the largest legal configuration (8 ports, 8-bit sizes)
  localparam int unsigned TAG_PORT_W = 3;
  localparam int unsigned TAG_CNT_W  = 8;
  localparam int unsigned STARVE_W   = 8;
  localparam logic [STARVE_W-1:0] STARVE_LIMIT = 8'd255;

  typedef struct packed {
    logic [TAG_PORT_W-1:0] port;
    logic [TAG_CNT_W-1:0]  remaining;
  } tag_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ddr_hp_mport_tag_fifo.sv
// In-order read tag FIFO: each entry counts down its outstanding read beats
// and is popped when the last beat returns.
module ddr_hp_mport_tag_fifo
  import ddr_hp_mport_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  tag_t                  tag_i,
  input  logic                  dec_i,
  output logic [TAG_PORT_W-1:0] head_port_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PTR_W = clog2(DEPTH);

  tag_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W:0]   cnt_q;
  tag_t             head;
  logic             pop;
  logic             push_ok;
  logic             dec_ok;

  assign head        = mem_q[rd_q];
  assign head_port_o = head.port;
  assign full_o      = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty_o     = (cnt_q == '0);
  assign dec_ok      = dec_i && !empty_o;
  assign pop         = dec_ok && (head.remaining <= TAG_CNT_W'(1));
  // A push into a full FIFO is only safe when the head slot is freed this cycle
  assign push_ok     = push_i && (!full_o || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + PTR_W'(1);
      if (pop)     rd_q <= rd_q + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= tag_i;
    if (dec_ok && !pop) mem_q[rd_q].remaining <= head.remaining - TAG_CNT_W'(1);
  end

endmodule

// File: rtl/ddr_hp_mport_arbiter.sv
// Multi-port Avalon front-end for the DDR2 HP controller local port.
// Define DDR_HP_MPORT_PRIORITY_EN for port-0 priority with starvation relief.
module ddr_hp_mport_arbiter
  import ddr_hp_mport_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned DATA_W    = 160,
  parameter int unsigned ADDR_W    = 23,
  parameter int unsigned SIZE_W    = 3,
  parameter int unsigned TAG_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            p_read_req,
  input  logic [NUM_PORTS-1:0]            p_write_req,
  input  logic [NUM_PORTS-1:0]            p_burstbegin,
  input  logic [NUM_PORTS*ADDR_W-1:0]     p_addr,
  input  logic [NUM_PORTS*SIZE_W-1:0]     p_size,
  input  logic [NUM_PORTS*DATA_W-1:0]     p_wdata,
  input  logic [NUM_PORTS*DATA_W/8-1:0]   p_be,
  output logic [NUM_PORTS-1:0]            p_ready,
  output logic [NUM_PORTS-1:0]            p_rdata_valid,
  output logic [DATA_W-1:0]               p_rdata,
  output logic                            local_read_req,
  output logic                            local_write_req,
  output logic                            local_burstbegin,
  output logic [ADDR_W-1:0]               local_addr,
  output logic [SIZE_W-1:0]               local_size,
  output logic [DATA_W-1:0]               local_wdata,
  output logic [DATA_W/8-1:0]             local_be,
  input  logic                            local_ready,
  input  logic                            local_init_done,
  input  logic [DATA_W-1:0]               local_rdata,
  input  logic                            local_rdata_valid
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned PTR_W = clog2(NUM_PORTS);

  state_e                 state_q;
  logic [PTR_W-1:0]       g_q;
  logic [PTR_W-1:0]       rr_q;
  logic [SIZE_W-1:0]      beat_q;
  logic                   first_q;
  logic                   err_orphan_q;
  logic [31:0]            g_idx;
  logic [SIZE_W-1:0]      size_raw;
  logic [SIZE_W-1:0]      size_g;
  logic [SIZE_W-1:0]      beats_left;
  logic [NUM_PORTS-1:0]   elig;
  logic [PTR_W-1:0]       rr_pick;
  logic [PTR_W-1:0]       pick;
  logic                   arb_go;
  logic                   active;
  logic                   rd_acc;
  logic                   wr_acc;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [TAG_PORT_W-1:0]  head_port;
  tag_t                   push_tag;

  function automatic logic [PTR_W-1:0] next_port(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_PORTS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Zero-latency command path from the granted port
  assign g_idx            = 32'(g_q);
  assign active           = (state_q != IDLE);
  assign size_raw         = p_size[g_idx*SIZE_W +: SIZE_W];
  assign size_g           = (size_raw == '0) ? SIZE_W'(1) : size_raw;
  assign local_addr       = p_addr[g_idx*ADDR_W +: ADDR_W];
  assign local_wdata      = p_wdata[g_idx*DATA_W +: DATA_W];
  assign local_be         = p_be[g_idx*BE_W +: BE_W];
  assign local_size       = size_g;
  assign local_read_req   = (state_q == RD_CMD) && p_read_req[g_q];
  assign local_write_req  = (state_q == WR_BURST) && p_write_req[g_q];
  assign local_burstbegin = active && p_burstbegin[g_q];
  assign rd_acc           = local_read_req && local_ready;
  assign wr_acc           = local_write_req && local_ready;
  assign beats_left       = (first_q ? size_g : beat_q) - SIZE_W'(1);
  assign p_rdata          = local_rdata;

  always_comb begin
    p_ready = '0;
    if (active) p_ready[g_q] = local_ready;
  end

  // Reads take precedence within a port; a read is ineligible while the tag FIFO is full
  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++)
      elig[i] = p_read_req[i] ? !fifo_full : p_write_req[i];
  end

  always_comb begin
    logic found;
    found   = 1'b0;
    rr_pick = rr_q;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      int unsigned idx;
      idx = 32'(rr_q) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && elig[idx]) begin
        rr_pick = PTR_W'(idx);
        found   = 1'b1;
      end
    end
  end

  assign arb_go = (state_q == IDLE) && local_init_done && (|elig);

`ifdef DDR_HP_MPORT_PRIORITY_EN
  logic [STARVE_W-1:0] starve_q [1:NUM_PORTS-1];
  logic                starving;

  always_comb begin
    starving = 1'b0;
    for (int i = 1; i < NUM_PORTS; i++)
      if (elig[i] && (starve_q[i] == STARVE_LIMIT)) starving = 1'b1;
    pick = (elig[0] && !starving) ? '0 : rr_pick;
  end

  // Count port-0 wins while each other port waits; cleared when that port wins
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NUM_PORTS; i++) starve_q[i] <= '0;
    end else if (arb_go) begin
      for (int i = 1; i < NUM_PORTS; i++) begin
        if (pick == PTR_W'(i))
          starve_q[i] <= '0;
        else if ((pick == '0) && elig[i] && (starve_q[i] != STARVE_LIMIT))
          starve_q[i] <= starve_q[i] + STARVE_W'(1);
      end
    end
  end
`else
  assign pick = rr_pick;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      g_q          <= '0;
      rr_q         <= '0;
      beat_q       <= '0;
      first_q      <= 1'b1;
      err_orphan_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_go) begin
            g_q     <= pick;
            first_q <= 1'b1;
            state_q <= p_read_req[pick] ? RD_CMD : WR_BURST;
          end
        end
        RD_CMD: begin
          if (rd_acc) begin
            rr_q    <= next_port(g_q);
            state_q <= IDLE;
          end
        end
        WR_BURST: begin
          if (wr_acc) begin
            first_q <= 1'b0;
            beat_q  <= beats_left;
            if (beats_left == '0) begin
              rr_q    <= next_port(g_q);
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      if (local_rdata_valid && fifo_empty) err_orphan_q <= 1'b1;
    end
  end

  always_comb begin
    push_tag.port      = TAG_PORT_W'(g_q);
    push_tag.remaining = TAG_CNT_W'(size_g);
  end

  ddr_hp_mport_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (rd_acc),
    .tag_i       (push_tag),
    .dec_i       (local_rdata_valid),
    .head_port_o (head_port),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++)
      p_rdata_valid[i] = local_rdata_valid && !fifo_empty && (head_port == TAG_PORT_W'(i));
  end

endmodule
